// File: rtl/rv32i_pkg.sv
// Shared RV32I opcode constants and instruction format enum
// for the instruction encoder slice.
package rv32i_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef enum logic [2:0] {
        FMT_R,
        FMT_I,
        FMT_S,
        FMT_B,
        FMT_U,
        FMT_J,
        FMT_BAD
    } fmt_t;

endpackage

// File: rtl/instr_pack.sv
// Combinational opcode-to-format selection and RV32I bit packing,
// inverse of the decoder's raw_imm layout.
module instr_pack
    import rv32i_pkg::*;
(
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [4:0]  rd,
    input  logic [19:0] raw_imm,
    output fmt_t        fmt,
    output logic [31:0] instr
);

    always_comb begin
        fmt = FMT_BAD;
        unique case (1'b1)
            (opcode == OP_R):
                fmt = FMT_R;
            (opcode == OP_IMM) || (opcode == OP_LOAD) ||
            (opcode == OP_JALR) || (opcode == OP_SYSTEM) ||
            (opcode == OP_FENCE):
                fmt = FMT_I;
            (opcode == OP_STORE):
                fmt = FMT_S;
            (opcode == OP_BRANCH):
                fmt = FMT_B;
            (opcode == OP_LUI) || (opcode == OP_AUIPC):
                fmt = FMT_U;
            (opcode == OP_JAL):
                fmt = FMT_J;
            default:
                fmt = FMT_BAD;
        endcase
    end

    // Unsupported opcodes fall through to R packing.
    always_comb begin
        instr = {funct7, rs2, rs1, funct3, rd, opcode};
        unique case (fmt)
            FMT_I:
                instr = {raw_imm[11:0], rs1, funct3,
                         rd, opcode};
            FMT_S:
                instr = {raw_imm[11:5], rs2, rs1, funct3,
                         raw_imm[4:0], opcode};
            FMT_B:
                instr = {raw_imm[11], raw_imm[9:4], rs2,
                         rs1, funct3, raw_imm[3:0],
                         raw_imm[10], opcode};
            FMT_U:
                instr = {raw_imm[19:0], rd, opcode};
            FMT_J:
                instr = {raw_imm[19], raw_imm[9:0],
                         raw_imm[10], raw_imm[18:11],
                         rd, opcode};
            default:
                instr = {funct7, rs2, rs1, funct3, rd, opcode};
        endcase
    end

endmodule

// File: rtl/instruction_encoder.sv
// Field-bundle to instruction-word encoder with output FIFO and address
// counter; INSTR_ENCODER_CHECK_EN enables unsupported-opcode filtering.
module instruction_encoder #(
    parameter int ADDR_WIDTH = 32,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [6:0]            opcode,
    input  logic [2:0]            funct3,
    input  logic [6:0]            funct7,
    input  logic [4:0]            rs1,
    input  logic [4:0]            rs2,
    input  logic [4:0]            rd,
    input  logic [19:0]           raw_imm,
    input  logic                  base_load,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [31:0]           instruction,
    output logic [ADDR_WIDTH-1:0] out_addr,
    output logic                  illegal,
    output logic [7:0]            illegal_count
);
    import rv32i_pkg::*;

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [31:0]           word_mem [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0] addr_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      count;
    logic [ADDR_WIDTH-1:0] counter;

    logic [31:0]           packed_word;
    fmt_t                  fmt;
    logic                  full;
    logic                  pop;
    logic                  accept;
    logic                  push;
    logic [ADDR_WIDTH-1:0] base;
    logic [ADDR_WIDTH-1:0] tag;
    logic                  unused_bits;

    instr_pack u_pack (
        .opcode  (opcode),
        .funct3  (funct3),
        .funct7  (funct7),
        .rs1     (rs1),
        .rs2     (rs2),
        .rd      (rd),
        .raw_imm (raw_imm),
        .fmt     (fmt),
        .instr   (packed_word)
    );

    assign full      = (count == CNT_W'(FIFO_DEPTH));
    assign out_valid = (count != '0);
    assign pop       = out_valid && out_ready;
    assign in_ready  = !full || pop;
    assign accept    = in_valid && in_ready;

    assign base = {base_addr[ADDR_WIDTH-1:2], 2'b00};
    // A same-cycle base_load redirects the word being accepted.
    assign tag  = base_load ? base : counter;

    assign instruction = word_mem[rd_ptr];
    assign out_addr    = addr_mem[rd_ptr];

`ifdef INSTR_ENCODER_CHECK_EN
    logic bad;
    assign bad         = (fmt == FMT_BAD);
    assign push        = accept && !bad;
    assign unused_bits = ^base_addr[1:0];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            illegal       <= 1'b0;
            illegal_count <= '0;
        end else begin
            illegal <= accept && bad;
            if (accept && bad && (illegal_count != 8'hFF))
                illegal_count <= illegal_count + 8'd1;
        end
    end
`else
    assign push          = accept;
    assign illegal       = 1'b0;
    assign illegal_count = '0;
    assign unused_bits   = ^{base_addr[1:0], (fmt == FMT_BAD)};
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                word_mem[i] <= '0;
                addr_mem[i] <= '0;
            end
        end else begin
            if (push) begin
                word_mem[wr_ptr] <= packed_word;
                addr_mem[wr_ptr] <= tag;
                wr_ptr           <= wr_ptr + PTR_W'(1);
            end
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            if (push && !pop)
                count <= count + CNT_W'(1);
            else if (!push && pop)
                count <= count - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            counter <= '0;
        else if (push)
            counter <= tag + ADDR_WIDTH'(4);
        else if (base_load)
            counter <= base;
    end

endmodule

// File: tb/tb_instruction_encoder.sv
// Randomized self-checking bench for instruction_encoder against a
// queue-based reference model; honours INSTR_ENCODER_CHECK_EN.
module tb_instruction_encoder;

    localparam int DEPTH = 2;
`ifdef INSTR_ENCODER_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [19:0] raw_imm;
    logic        base_load;
    logic [31:0] base_addr;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] instruction;
    logic [31:0] out_addr;
    logic        illegal;
    logic [7:0]  illegal_count;

    instruction_encoder #(.ADDR_WIDTH(32), .FIFO_DEPTH(DEPTH)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .opcode        (opcode),
        .funct3        (funct3),
        .funct7        (funct7),
        .rs1           (rs1),
        .rs2           (rs2),
        .rd            (rd),
        .raw_imm       (raw_imm),
        .base_load     (base_load),
        .base_addr     (base_addr),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .instruction   (instruction),
        .out_addr      (out_addr),
        .illegal       (illegal),
        .illegal_count (illegal_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] w;
        logic [31:0] a;
    } ent_t;

    ent_t        q[$];
    logic [31:0] m_ctr;
    logic        m_ill;
    int          m_cnt;
    int          vectors = 0;
    int          miscompares = 0;

    logic [6:0] ops [11] = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h73,
                             7'h0F, 7'h23, 7'h63, 7'h37, 7'h17,
                             7'h6F};

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bit supported(input logic [6:0] op);
        foreach (ops[i]) if (ops[i] == op) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] enc(input logic [6:0] op,
        input logic [2:0] f3, input logic [6:0] f7,
        input logic [4:0] s1, input logic [4:0] s2,
        input logic [4:0] d, input logic [19:0] im);
        logic [31:0] o, r1, r2, dd, ff3, ff7, i;
        o = 32'(op); r1 = 32'(s1); r2 = 32'(s2); dd = 32'(d);
        ff3 = 32'(f3); ff7 = 32'(f7); i = 32'(im);
        case (op)
            7'h13, 7'h03, 7'h67, 7'h73, 7'h0F:
                return ((i & 32'hFFF) << 20) | (r1 << 15) |
                       (ff3 << 12) | (dd << 7) | o;
            7'h23:
                return (((i >> 5) & 32'h7F) << 25) | (r2 << 20) |
                       (r1 << 15) | (ff3 << 12) |
                       ((i & 32'h1F) << 7) | o;
            7'h63:
                return (((i >> 11) & 1) << 31) |
                       (((i >> 4) & 32'h3F) << 25) | (r2 << 20) |
                       (r1 << 15) | (ff3 << 12) |
                       ((i & 32'hF) << 8) |
                       (((i >> 10) & 1) << 7) | o;
            7'h37, 7'h17:
                return (i << 12) | (dd << 7) | o;
            7'h6F:
                return (((i >> 19) & 1) << 31) |
                       ((i & 32'h3FF) << 21) |
                       (((i >> 10) & 1) << 20) |
                       (((i >> 11) & 32'hFF) << 12) |
                       (dd << 7) | o;
            default:
                return (ff7 << 25) | (r2 << 20) | (r1 << 15) |
                       (ff3 << 12) | (dd << 7) | o;
        endcase
    endfunction

    task automatic model_clear();
        q.delete();
        m_ctr = 32'h0;
        m_ill = 1'b0;
        m_cnt = 0;
    endtask

    // One clock: check outputs at negedge, advance the model at posedge.
    task automatic cycle();
        bit exp_ready, acc, pop, bad;
        logic [31:0] b;
        @(negedge clk);
        exp_ready = (q.size() < DEPTH) || (q.size() > 0 && out_ready);
        check("in_ready", 32'(in_ready), 32'(exp_ready));
        check("out_valid", 32'(out_valid), 32'(q.size() > 0));
        if (q.size() > 0) begin
            check("instruction", instruction, q[0].w);
            check("out_addr", out_addr, q[0].a);
        end
        check("illegal", 32'(illegal), 32'(m_ill));
        check("illegal_count", 32'(illegal_count), 32'(m_cnt));
        acc = in_valid && exp_ready;
        pop = (q.size() > 0) && out_ready;
        bad = !supported(opcode);
        b = base_load ? (base_addr & 32'hFFFFFFFC) : m_ctr;
        @(posedge clk);
        if (pop) void'(q.pop_front());
        m_ill = acc && bad && CHK;
        if (m_ill) begin
            if (m_cnt < 255) m_cnt++;
            m_ctr = b;
        end else if (acc) begin
            q.push_back('{enc(opcode, funct3, funct7, rs1, rs2, rd,
                              raw_imm), b});
            m_ctr = b + 32'd4;
        end else begin
            m_ctr = b;
        end
        #1;
    endtask

    task automatic drive(input logic [6:0] op, input logic [2:0] f3,
        input logic [6:0] f7, input logic [4:0] s1,
        input logic [4:0] s2, input logic [4:0] d,
        input logic [19:0] im);
        in_valid = 1'b1;
        opcode = op; funct3 = f3; funct7 = f7;
        rs1 = s1; rs2 = s2; rd = d; raw_imm = im;
    endtask

    task automatic drive_rand(input logic [6:0] op);
        drive(op, 3'($urandom), 7'($urandom), 5'($urandom),
              5'($urandom), 5'($urandom), 20'($urandom));
    endtask

    initial begin
        reset_n = 1'b0;
        in_valid = 1'b0; base_load = 1'b0; base_addr = '0;
        out_ready = 1'b0;
        drive(7'h0, 3'h0, 7'h0, 5'h0, 5'h0, 5'h0, 20'h0);
        in_valid = 1'b0;
        model_clear();
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_instruction", instruction, 32'h0);
        check("rst_out_addr", out_addr, 32'h0);
        check("rst_illegal", 32'(illegal), 32'd0);
        check("rst_illegal_count", 32'(illegal_count), 32'd0);
        reset_n = 1'b1;
        cycle();

        drive(7'b0110011, 3'b000, 7'b0100000, 5'b01010, 5'b10101,
              5'b10001, 20'h0);
        base_load = 1'b1; base_addr = 32'h100;
        cycle();
        check("r_type_word", instruction, 32'h415508B3);
        check("r_type_addr", out_addr, 32'h100);
        in_valid = 1'b0; base_load = 1'b0; out_ready = 1'b1;
        cycle();

        drive(7'b1100011, 3'b110, 7'h0, 5'b00101, 5'b01101, 5'h0,
              20'h00C9C);
        cycle();
        check("b_type_word", instruction, 32'h92D2ECE3);
        drive(7'b1101111, 3'h0, 7'h0, 5'h0, 5'h0, 5'b00111,
              20'hE768E);
        cycle();
        check("j_type_word", instruction, 32'hD1DCE3EF);
        in_valid = 1'b0;
        cycle();

        out_ready = 1'b0;
        base_load = 1'b1; base_addr = 32'h203;
        drive_rand(ops[$urandom_range(10)]);
        cycle();
        base_load = 1'b0;
        drive_rand(ops[$urandom_range(10)]);
        cycle();
        check("bp_in_ready_low", 32'(in_ready), 32'd0);
        drive_rand(ops[$urandom_range(10)]);
        cycle();
        out_ready = 1'b1;
        cycle();
        check("bp_second_addr", out_addr, 32'h204);
        in_valid = 1'b0;
        repeat (3) cycle();

        out_ready = 1'b0;
        base_load = 1'b1; base_addr = 32'hFFFFFFFC;
        drive_rand(ops[$urandom_range(10)]);
        cycle();
        check("wrap_addr0", out_addr, 32'hFFFFFFFC);
        base_load = 1'b0;
        cycle();
        in_valid = 1'b0; out_ready = 1'b1;
        cycle();
        check("wrap_addr1", out_addr, 32'h0);
        cycle();

        out_ready = 1'b0;
        drive(7'h7F, 3'h0, 7'h0, 5'h0, 5'h0, 5'h0, 20'h0);
        cycle();
`ifdef INSTR_ENCODER_CHECK_EN
        check("bad_illegal", 32'(illegal), 32'd1);
        check("bad_count", 32'(illegal_count), 32'd1);
        check("bad_no_push", 32'(out_valid), 32'd0);
`else
        check("bad_pushed", 32'(out_valid), 32'd1);
        check("bad_r_word", instruction, 32'h0000007F);
`endif
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (2) cycle();

        for (int i = 0; i < 300; i++) begin
            drive_rand(7'h7F);
            cycle();
        end
        in_valid = 1'b0;
        cycle();
`ifdef INSTR_ENCODER_CHECK_EN
        check("sat_count", 32'(illegal_count), 32'd255);
`endif

        for (int i = 0; i < 3000; i++) begin
            in_valid = ($urandom_range(3) != 0);
            out_ready = ($urandom_range(3) != 0);
            base_load = ($urandom_range(15) == 0);
            base_addr = $urandom;
            if ($urandom_range(7) == 0)
                drive_rand(7'($urandom));
            else
                drive_rand(ops[$urandom_range(10)]);
            in_valid = ($urandom_range(3) != 0);
            cycle();
            if (i == 1500) begin
                reset_n = 1'b0;
                #2;
                check("mid_rst_out_valid", 32'(out_valid), 32'd0);
                check("mid_rst_in_ready", 32'(in_ready), 32'd1);
                check("mid_rst_count", 32'(illegal_count), 32'd0);
                model_clear();
                @(posedge clk);
                #1;
                reset_n = 1'b1;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
